// File: rtl/arbol_sumadores_secuenciador.sv
// Sequencer for the 8-input pipelined adder tree: streams len beats into the tree,
// tracks them through its fixed latency and accumulates the returning partial sums.
module arbol_sumadores_secuenciador #(
  parameter int WIDTH = 8,
  parameter int LAT   = 3,
  parameter int BEATW = 4,
  parameter int ACCW  = WIDTH + 3 + BEATW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BEATW-1:0]        len,
  output logic                    busy,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [8*WIDTH-1:0]      s_data,
  output logic [8*WIDTH-1:0]      tree_in,
  input  logic signed [WIDTH+2:0] tree_result,
  output logic                    done,
  output logic signed [ACCW-1:0]  sum
);

  localparam int TW = WIDTH + 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FEED  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [BEATW-1:0] len_q, len_d;
  logic [BEATW-1:0] issued_q, issued_d;
  logic [BEATW-1:0] returned_q, returned_d;
  logic [LAT-1:0]   vpipe_q, vpipe_d;
  logic [ACCW-1:0]  sum_q, sum_d;

  logic            fire;
  logic            marked;
  logic [ACCW-1:0] result_ext;

  assign s_ready    = (state_q == ST_FEED);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign fire       = s_valid & s_ready;
  assign tree_in    = fire ? s_data : '0;
  assign marked     = vpipe_q[LAT-1];
  assign result_ext = {{(ACCW-TW){tree_result[TW-1]}}, tree_result};
  assign sum        = sum_q;

  // Valid pipe mirrors the tree latency so only results of issued beats are summed.
  always_comb begin
    vpipe_d    = '0;
    vpipe_d[0] = fire;
    for (int i = 1; i < LAT; i++) begin
      vpipe_d[i] = vpipe_q[i-1];
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    issued_d   = issued_q + BEATW'(fire);
    returned_d = returned_q + BEATW'(marked);
    sum_d      = marked ? (sum_q + result_ext) : sum_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sum_d = '0;
          if (len != '0) begin
            len_d      = len;
            issued_d   = '0;
            returned_d = '0;
            state_d    = ST_FEED;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_FEED: begin
        if (fire && (issued_q == len_q - BEATW'(1))) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (marked && (returned_q == len_q - BEATW'(1))) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      vpipe_q    <= '0;
      sum_q      <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      returned_q <= returned_d;
      vpipe_q    <= vpipe_d;
      sum_q      <= sum_d;
    end
  end

endmodule
